sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter and access sequencer for the external 128-bit SRAM. It shares the single SRAM port between a write requester (the packed init stream) and a read requester, using round-robin arbitration. Each granted access is converted into a fixed-length chip-enable/write-enable/output-enable sequence. It sits between the stream packer/readback logic and the top-level SRAM pins; the top level implements the tristate DQ bus using `sram_dq_oe`.

## Interface
- `ADDR_W`, 19, SRAM word address width
- `DATA_W`, 128, SRAM word width
- `WR_CYC`, 2, cycles `sram_we_n` is held low per write (≥1)
- `RD_CYC`, 2, cycles `sram_oe_n` is held low per read (≥1); data is sampled on the last one

- `CLK`  in  1  sole clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `wr_req`  in  1  write request, level, held until `wr_ack`
- `wr_addr`  in  ADDR_W  write address, sampled at grant
- `wr_data`  in  DATA_W  write data, sampled at grant
- `wr_ack`  out  1  one-cycle pulse, write complete
- `rd_req`  in  1  read request, level, held until `rd_ack`
- `rd_addr`  in  ADDR_W  read address, sampled at grant
- `rd_ack`  out  1  one-cycle pulse, `rd_data` valid
- `rd_data`  out  DATA_W  last read word, held until the next read completes
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_dout`  out  DATA_W  data driven to SRAM
- `sram_din`  in  DATA_W  data from SRAM
- `sram_ce_n`, `sram_we_n`, `sram_oe_n`  out  1 each  SRAM strobes, active-low
- `sram_dq_oe`  out  1  DQ drive enable for the top-level tristate
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state=IDLE; `last_grant`=READ, so a write wins the first tie.
  - `sram_ce_n`=`sram_we_n`=`sram_oe_n`=1; `sram_dq_oe`=0.
  - `sram_addr`=0, `sram_dout`=0, `rd_data`=0.
  - `wr_ack`=`rd_ack`=0; `busy`=0; cycle counter=0.
- FSM states: IDLE, WRITE, READ, ACK.
- IDLE, arbitration:
  - If only one request is high, grant it.
  - If both are high, grant the side opposite `last_grant`.
  - On grant: latch address into `sram_addr` (and `wr_data` into `sram_dout` for writes); update `last_grant`; load counter with `WR_CYC-1` or `RD_CYC-1`.
- WRITE:
  - Outputs: `sram_ce_n`=0, `sram_we_n`=0, `sram_dq_oe`=1.
  - Counter decrements each cycle; at 0, go to ACK.
- READ:
  - Outputs: `sram_ce_n`=0, `sram_oe_n`=0, `sram_dq_oe`=0.
  - At counter 0, capture `sram_din` into `rd_data` and go to ACK.
- ACK, one cycle:
  - Strobes are inactive (`we_n`=`oe_n`=1, `ce_n`=1).
  - After a write, `sram_dq_oe` stays 1 for data hold; otherwise it is 0.
  - Pulse `wr_ack` or `rd_ack` according to the granted side.
  - Always return to IDLE.
- Requesters must not change address/data while their request is pending. The address is latched at grant, so later changes are ignored regardless.
- A requester that drops its request before grant is simply not served. A request dropped after grant still completes and is still acked.
- `sram_addr` and `sram_dout` hold their last values in IDLE.
- `rd_data` changes only on the last READ cycle.
- `rd_ack` and `wr_ack` are never high in the same cycle.

## Timing
- Request high in IDLE at cycle 0 → grant edge → WRITE/READ occupies cycles 1..N (N=`WR_CYC` or `RD_CYC`) → ACK in cycle N+1 → IDLE in cycle N+2.
- Ack latency: N+1 cycles from the first IDLE cycle that sees the request.
- Minimum access period: N+2 cycles. Back-to-back requests from the same side with the other side idle are served every N+2 cycles.
- Under continuous contention, grants alternate W, R, W, R…; the first grant after reset is W.
- `sram_din` must be valid by the rising edge that ends read cycle N.
- Requesters register `*_ack` and deassert `*_req` on the following edge. The IDLE cycle after ACK therefore sees the dropped request, so no duplicate access occurs.

## Test plan
- Single write:
  - Stimulus: `WR_CYC`=2, `wr_req`=1 with `wr_addr`=0x00005 and `wr_data`=0x…DEADBEEF.
  - Required: `sram_we_n` low for exactly cycles 1–2; `sram_addr`=0x00005 and `sram_dout`=0x…DEADBEEF over cycles 1–3; `wr_ack` pulses in cycle 3; `busy` returns to 0 in cycle 4.
- Single read:
  - Stimulus: `RD_CYC`=2, `rd_addr`=0x7FFFF; the SRAM model drives `sram_din`=0x0123…CDEF.
  - Required: `sram_oe_n` low in cycles 1–2; `sram_dq_oe`=0 throughout; `rd_ack` in cycle 3 with `rd_data`=0x0123…CDEF; `rd_data` held thereafter.
- Simultaneous requests after reset:
  - Stimulus: `wr_req` and `rd_req` asserted in the same cycle.
  - Required: the write is served first (`wr_ack` at cycle 3); the read is granted in cycle 4 (`rd_ack` at cycle 7).
- Sustained contention:
  - Stimulus: both requesters re-request immediately after each ack, for 8 accesses.
  - Required: grant order W,R,W,R,W,R,W,R; one access every 4 cycles; no cycle with both acks high.
- Reset mid-write:
  - Stimulus: assert `RST` asynchronously in WRITE cycle 1.
  - Required: `sram_we_n`/`sram_ce_n` go to 1 and `sram_dq_oe` to 0 without waiting for a clock edge; no `wr_ack`; after release, a pending `rd_req` and `wr_req` tie is resolved write-first.
- Back-to-back writes:
  - Stimulus: 4 writes to addresses 0–3 with the read side idle.
  - Required: `wr_ack` every 4 cycles; the SRAM model holds the 4 words at addresses 0–3 in order.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signals of the SRAM arbiter, bundled as one interface.
// slave = arbiter side; master = requesters, SRAM model and pin logic.
interface sram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 128
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout;
  logic [DATA_W-1:0] sram_din;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_dq_oe;
  logic              busy;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_din,
    output wr_ack, rd_ack, rd_data, sram_addr, sram_dout,
           sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_din,
    input  wr_ack, rd_ack, rd_data, sram_addr, sram_dout,
           sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin write/read arbiter for the external SRAM; each grant runs a fixed
// CE/WE/OE strobe sequence. Every output is registered.
module sram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 128,
  parameter int WR_CYC = 2,
  parameter int RD_CYC = 2
) (
  input  logic            CLK,
  input  logic            RST,
  sram_arbiter_if.slave   bus
);

  localparam int MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_wr_q, last_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rd_data_d = rd_data_q;

    case (state_q)
      S_IDLE: begin
        // Write wins unless both are pending and the write side was served last.
        if (bus.wr_req && (!bus.rd_req || !last_wr_q)) begin
          state_d   = S_WRITE;
          last_wr_d = 1'b1;
          addr_d    = bus.wr_addr;
          dout_d    = bus.wr_data;
          cnt_d     = CNT_W'(WR_CYC - 1);
        end else if (bus.rd_req) begin
          state_d   = S_READ;
          last_wr_d = 1'b0;
          addr_d    = bus.rd_addr;
          cnt_d     = CNT_W'(RD_CYC - 1);
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_READ: begin
        if (cnt_q == '0) begin
          state_d   = S_ACK;
          rd_data_d = bus.sram_din;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered with it.
    ce_n_d   = !((state_d == S_WRITE) || (state_d == S_READ));
    we_n_d   = (state_d != S_WRITE);
    oe_n_d   = (state_d != S_READ);
    dq_oe_d  = (state_d == S_WRITE) || ((state_q == S_WRITE) && (state_d == S_ACK));
    wr_ack_d = (state_q == S_WRITE) && (state_d == S_ACK);
    rd_ack_d = (state_q == S_READ) && (state_d == S_ACK);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      rd_data_q <= '0;
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rd_data_q <= rd_data_d;
      ce_n_q    <= ce_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      dq_oe_q   <= dq_oe_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sram_addr  = addr_q;
  assign bus.sram_dout  = dout_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: inputs driven and outputs sampled on the
// falling edge; cycle k is the k-th falling edge after a request is raised.
module tb_sram_arbiter;

  localparam logic [127:0] W0   = 128'h1111_2222_3333_4444_5555_6666_DEAD_BEEF;
  localparam logic [127:0] W1   = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_0000_0010;
  localparam logic [127:0] W2   = 128'hFFFF_0000_FFFF_0000_AAAA_5555_0000_0040;
  localparam logic [127:0] W3   = 128'h3333_3333_3333_3333_3333_3333_0000_0020;
  localparam logic [127:0] RPAT = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;
  int   n_acks;

  logic [127:0] mem [logic [18:0]];

  sram_arbiter_if #(.ADDR_W(19), .DATA_W(128)) bus ();

  sram_arbiter #(
    .ADDR_W(19),
    .DATA_W(128),
    .WR_CYC(2),
    .RD_CYC(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: writes on the rising edge, read data presented well before it.
  always @(posedge CLK)
    if (!bus.sram_ce_n && !bus.sram_we_n) mem[bus.sram_addr] = bus.sram_dout;

  always @(negedge CLK)
    bus.sram_din <= mem.exists(bus.sram_addr) ? mem[bus.sram_addr] : '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem[19'h7FFFF] = RPAT;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    RST = 1'b1;
    #1;
    check("rst_ce_n",  bus.sram_ce_n, 1);
    check("rst_we_n",  bus.sram_we_n, 1);
    check("rst_oe_n",  bus.sram_oe_n, 1);
    check("rst_dq_oe", bus.sram_dq_oe, 0);
    check("rst_addr",  bus.sram_addr, 0);
    check("rst_dout",  bus.sram_dout, 0);
    check("rst_rdata", bus.rd_data, 0);
    check("rst_acks",  {bus.wr_ack, bus.rd_ack}, 0);
    check("rst_busy",  bus.busy, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Single write
    bus.wr_addr = 19'h00005;
    bus.wr_data = W0;
    bus.wr_req  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (c <= 2) begin
        check("sw_we_n", bus.sram_we_n, 0);
        check("sw_ce_n", bus.sram_ce_n, 0);
        check("sw_dqoe", bus.sram_dq_oe, 1);
        check("sw_ack_early", bus.wr_ack, 0);
      end
      if (c <= 3) begin
        check("sw_addr", bus.sram_addr, 19'h00005);
        check("sw_dout", bus.sram_dout, W0);
      end
      if (c == 3) begin
        check("sw_we_n_ack", bus.sram_we_n, 1);
        check("sw_ce_n_ack", bus.sram_ce_n, 1);
        check("sw_ack", bus.wr_ack, 1);
        check("sw_dqoe_hold", bus.sram_dq_oe, 1);
        bus.wr_req = 1'b0;
      end
      if (c == 4) begin
        check("sw_busy_end", bus.busy, 0);
        check("sw_ack_end", bus.wr_ack, 0);
        check("sw_dqoe_end", bus.sram_dq_oe, 0);
      end
    end

    // Single read
    bus.rd_addr = 19'h7FFFF;
    bus.rd_req  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      check("sr_dqoe", bus.sram_dq_oe, 0);
      if (c <= 2) begin
        check("sr_oe_n", bus.sram_oe_n, 0);
        check("sr_rdata_early", bus.rd_data, 0);
        check("sr_ack_early", bus.rd_ack, 0);
      end
      if (c == 3) begin
        check("sr_ack", bus.rd_ack, 1);
        check("sr_rdata", bus.rd_data, RPAT);
        check("sr_oe_n_ack", bus.sram_oe_n, 1);
        bus.rd_req = 1'b0;
      end
      if (c == 5) begin
        check("sr_rdata_held", bus.rd_data, RPAT);
        check("sr_busy_end", bus.busy, 0);
      end
    end

    // Simultaneous requests after reset: write first
    pulse_reset();
    bus.wr_addr = 19'h00010;
    bus.wr_data = W1;
    bus.rd_addr = 19'h00005;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      check("tie_ack_excl", bus.wr_ack & bus.rd_ack, 0);
      if (c == 3) begin
        check("tie_wr_ack", bus.wr_ack, 1);
        check("tie_rd_ack_early", bus.rd_ack, 0);
        bus.wr_req = 1'b0;
      end
      if (c == 4) check("tie_idle", bus.busy, 0);
      if (c == 5) begin
        check("tie_rd_oe_n", bus.sram_oe_n, 0);
        check("tie_rd_addr", bus.sram_addr, 19'h00005);
      end
      if (c == 7) begin
        check("tie_rd_ack", bus.rd_ack, 1);
        check("tie_rd_data", bus.rd_data, W0);
        bus.rd_req = 1'b0;
      end
      if (c == 8) check("tie_busy_end", bus.busy, 0);
    end

    // Sustained contention
    bus.wr_addr = 19'h00040;
    bus.wr_data = W2;
    bus.rd_addr = 19'h00010;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    n_acks = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      check("cont_ack_excl", bus.wr_ack & bus.rd_ack, 0);
      if (bus.wr_ack || bus.rd_ack) begin
        check("cont_order", bus.rd_ack, n_acks % 2);
        check("cont_period", c, 3 + 4 * n_acks);
        if (bus.rd_ack) check("cont_rdata", bus.rd_data, W1);
        n_acks++;
        if (n_acks == 8) break;
      end
    end
    check("cont_count", n_acks, 8);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge CLK);
    check("cont_idle", bus.busy, 0);
    check("cont_mem", mem[19'h00040], W2);

    // Reset mid-write
    bus.wr_addr = 19'h00020;
    bus.wr_data = W3;
    bus.wr_req  = 1'b1;
    @(negedge CLK);
    check("rmw_we_n_active", bus.sram_we_n, 0);
    #2;
    RST = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    check("rmw_we_n", bus.sram_we_n, 1);
    check("rmw_ce_n", bus.sram_ce_n, 1);
    check("rmw_dqoe", bus.sram_dq_oe, 0);
    check("rmw_busy", bus.busy, 0);
    @(negedge CLK);
    check("rmw_no_ack", bus.wr_ack, 0);
    RST = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (c == 3) begin
        check("rmw_wr_first", bus.wr_ack, 1);
        check("rmw_rd_not_first", bus.rd_ack, 0);
        check("rmw_addr", bus.sram_addr, 19'h00020);
        bus.wr_req = 1'b0;
      end
      if (c == 7) begin
        check("rmw_rd_ack", bus.rd_ack, 1);
        check("rmw_rd_data", bus.rd_data, W1);
        bus.rd_req = 1'b0;
      end
    end

    // Back-to-back writes to addresses 0..3
    bus.wr_addr = 19'd0;
    bus.wr_data = {4{32'hA5A5_0000}};
    bus.wr_req  = 1'b1;
    n_acks = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      check("b2b_no_rd_ack", bus.rd_ack, 0);
      if (bus.wr_ack) begin
        check("b2b_period", c, 3 + 4 * n_acks);
        n_acks++;
        if (n_acks == 4) begin
          bus.wr_req = 1'b0;
          break;
        end
        bus.wr_addr = 19'(n_acks);
        bus.wr_data = {4{32'hA5A5_0000 | 32'(n_acks)}};
      end
    end
    check("b2b_count", n_acks, 4);
    @(negedge CLK);
    @(negedge CLK);
    check("b2b_idle", bus.busy, 0);
    check("b2b_mem0", mem[19'd0], {4{32'hA5A5_0000}});
    check("b2b_mem1", mem[19'd1], {4{32'hA5A5_0001}});
    check("b2b_mem2", mem[19'd2], {4{32'hA5A5_0002}});
    check("b2b_mem3", mem[19'd3], {4{32'hA5A5_0003}});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
